// File: rtl/inv_cipher_ctrl.sv
// inv_cipher_ctrl: round sequencer for an external iterative AES inverse-cipher datapath.
// Define INV_CIPHER_ABORT_EN to add an abort input that drops an in-flight block.
module inv_cipher_ctrl #(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic         clk,
  input  logic         rst,
`ifdef INV_CIPHER_ABORT_EN
  input  logic         abort,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_data,
  output logic [127:0] rnd_state,
  output logic [127:0] rnd_key,
  output logic         rnd_last,
  input  logic [127:0] rnd_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);
  localparam logic [3:0] LAST = 4'(Nr);
  if (Nr != Nk + 6) begin : g_bad_cfg
    $error("inv_cipher_ctrl: Nr must equal Nk+6");
  end
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
  state_t state;
  logic [3:0] cnt;
  logic [127:0] state_reg;
  logic kill;
`ifdef INV_CIPHER_ABORT_EN
  assign kill = abort && state != IDLE;
`else
  assign kill = 1'b0;
`endif
  assign rnd_state = state_reg;
  assign rnd_key = rk_data;
  assign out_data = state_reg;
  // rk_idx and rnd_last are registered one step ahead so they line up with cnt
  always_ff @(posedge clk) begin
    if (rst || kill) begin
      state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      rnd_last <= 1'b0;
      rk_idx <= LAST;
      if (rst) begin
        cnt <= 4'd0;
        state_reg <= '0;
      end
    end else case (state)
      IDLE: if (in_valid) begin
        state <= ROUND;
        state_reg <= in_data ^ rk_data;
        cnt <= LAST - 4'd1;
        rk_idx <= LAST - 4'd1;
        rnd_last <= LAST == 4'd1;
        in_ready <= 1'b0;
      end
      ROUND: begin
        state_reg <= rnd_out;
        if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
          rk_idx <= cnt - 4'd1;
          rnd_last <= cnt == 4'd1;
        end else begin
          state <= DONE;
          out_valid <= 1'b1;
          rnd_last <= 1'b0;
          rk_idx <= LAST;
        end
      end
      DONE: if (out_ready) begin
        state <= IDLE;
        out_valid <= 1'b0;
        in_ready <= 1'b1;
      end
      default: state <= IDLE;
    endcase
  end
endmodule

// File: tb/tb_inv_cipher_ctrl.sv
// tb_inv_cipher_ctrl: AES-128 and AES-256 controllers driven with random round-trip blocks,
// checked against a forward AES model and a cycle-count view of the handshake.
module tb_inv_cipher_ctrl;
  logic clk = 0, rst = 1;
  logic in_valid [2], in_ready [2], rnd_last [2], out_valid [2], out_ready [2];
  logic [3:0] rk_idx [2];
  logic [127:0] in_data [2], rk_data [2], rnd_state [2], rnd_key [2], rnd_out [2], out_data [2];
`ifdef INV_CIPHER_ABORT_EN
  logic abort [2];
`endif
  logic [7:0] sbox [256], inv_sbox [256];
  logic [127:0] rk [2][15];
  logic [127:0] cur_pt [2], exp_pt [2], init_st [2];
  bit busy [2], mon_en;
  int cyc = 0, acc_cyc [2], acc_n [2], compared = 0, mismatched = 0;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] gb(logic [127:0] s, int i);
    return s[127 - 8*i -: 8];
  endfunction

  function automatic logic [127:0] sub(logic [127:0] s, bit inv);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = inv ? inv_sbox[gb(s, i)] : sbox[gb(s, i)];
    return o;
  endfunction

  function automatic logic [127:0] shift(logic [127:0] s, bit inv);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(r + 4*c) -: 8] = gb(s, r + 4*((inv ? c - r + 4 : c + r) % 4));
    return o;
  endfunction

  function automatic logic [127:0] mix(logic [127:0] s, bit inv);
    logic [127:0] o;
    logic [7:0] k [4];
    logic [7:0] v;
    if (inv) k = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else k = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        v = 8'h00;
        for (int j = 0; j < 4; j++) v ^= gmul(gb(s, j + 4*c), k[(j - r + 4) % 4]);
        o[127 - 8*(r + 4*c) -: 8] = v;
      end
    return o;
  endfunction

  function automatic logic [31:0] subw(logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  // Round keys for instance d; the 128-bit key sits in the upper half of key.
  task automatic expand(int d, logic [255:0] key);
    int nk = d ? 8 : 4;
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0] rcon = 8'h01;
    for (int i = 0; i < 60; i++) begin
      if (i < nk) w[i] = key[255 - 32*i -: 32];
      else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
          rcon = gmul(rcon, 8'h02);
        end else if (nk > 6 && i % nk == 4) t = subw(t);
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int r = 0; r < 15; r++) rk[d][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] encrypt(int d, logic [127:0] pt);
    int nr = d ? 14 : 10;
    logic [127:0] s = pt ^ rk[d][0];
    for (int r = 1; r <= nr; r++) begin
      s = shift(sub(s, 0), 0);
      if (r != nr) s = mix(s, 0);
      s ^= rk[d][r];
    end
    return s;
  endfunction

  function automatic logic [127:0] inv_round(logic [127:0] s, logic [127:0] k, logic last);
    logic [127:0] t = sub(shift(s, 1), 1) ^ k;
    return last ? t : mix(t, 1);
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gd
    assign rk_data[g] = rk_idx[g] < 4'd15 ? rk[g][rk_idx[g]] : '0;
    assign rnd_out[g] = inv_round(rnd_state[g], rnd_key[g], rnd_last[g]);
    inv_cipher_ctrl #(.Nk(g ? 8 : 4), .Nr(g ? 14 : 10)) u_dut (
      .clk(clk),
      .rst(rst),
`ifdef INV_CIPHER_ABORT_EN
      .abort(abort[g]),
`endif
      .in_valid(in_valid[g]),
      .in_ready(in_ready[g]),
      .in_data(in_data[g]),
      .rk_idx(rk_idx[g]),
      .rk_data(rk_data[g]),
      .rnd_state(rnd_state[g]),
      .rnd_key(rnd_key[g]),
      .rnd_last(rnd_last[g]),
      .rnd_out(rnd_out[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .out_data(out_data[g])
    );
  end

  task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Expected outputs follow from cycles elapsed since acceptance (t), not from any state encoding.
  initial forever begin
    int nr, t;
    @(negedge clk);
    if (mon_en) for (int d = 0; d < 2; d++) begin
      nr = d ? 14 : 10;
      t = cyc - acc_cyc[d];
      chk($sformatf("%0d.in_ready", d), 128'(in_ready[d]), 128'(!busy[d]));
      chk($sformatf("%0d.out_valid", d), 128'(out_valid[d]), 128'(busy[d] && t > nr));
      chk($sformatf("%0d.rnd_last", d), 128'(rnd_last[d]), 128'(busy[d] && t == nr));
      chk($sformatf("%0d.rnd_key", d), rnd_key[d], rk_data[d]);
      if (!busy[d] || t <= nr) chk($sformatf("%0d.rk_idx", d), 128'(rk_idx[d]), 128'(busy[d] ? nr - t : nr));
      if (busy[d] && t == 1) chk($sformatf("%0d.first_state", d), rnd_state[d], init_st[d]);
      if (busy[d] && t > nr) begin
        chk($sformatf("%0d.out_data", d), out_data[d], exp_pt[d]);
        chk($sformatf("%0d.rnd_state", d), rnd_state[d], exp_pt[d]);
      end
      if (rst) busy[d] = 0;
`ifdef INV_CIPHER_ABORT_EN
      else if (abort[d] && busy[d]) busy[d] = 0;
`endif
      else if (!busy[d] && in_valid[d]) begin
        busy[d] = 1;
        acc_cyc[d] = cyc;
        exp_pt[d] = cur_pt[d];
        init_st[d] = in_data[d] ^ rk[d][nr];
        acc_n[d]++;
      end else if (busy[d] && t > nr && out_ready[d]) busy[d] = 0;
    end
  end

  task automatic send(int d, logic [127:0] ct, logic [127:0] pt);
    int n = acc_n[d];
    in_data[d] = ct;
    cur_pt[d] = pt;
    in_valid[d] = 1;
    for (int i = 0; i < 50 && acc_n[d] == n; i++) step();
    chk($sformatf("%0d.accept", d), 128'(acc_n[d] - n), 128'(1));
    in_valid[d] = 0;
    in_data[d] = rand128();
  endtask

  task automatic wait_out(int d, int hold);
    for (int i = 0; i < 40 && !out_valid[d]; i++) begin
      in_valid[d] = 1'($urandom_range(0, 1));
      in_data[d] = rand128();
      out_ready[d] = 1'($urandom_range(0, 1));
      step();
    end
    in_valid[d] = 0;
    out_ready[d] = 0;
    chk($sformatf("%0d.out_arrives", d), 128'(out_valid[d]), 128'(1));
    repeat (hold) step();
    out_ready[d] = 1;
    step();
    out_ready[d] = 0;
  endtask

  initial begin
    logic [7:0] v, b;
    logic [127:0] pt;
    logic [127:0] pts [3];
    int acc [3];
    for (int x = 0; x < 256; x++) begin
      v = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) v = 8'(y);
      b = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
      sbox[x] = b;
      inv_sbox[b] = 8'(x);
    end
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 0;
      out_ready[d] = 0;
      in_data[d] = '0;
      cur_pt[d] = '0;
`ifdef INV_CIPHER_ABORT_EN
      abort[d] = 0;
`endif
    end
    expand(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
    expand(1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    repeat (3) step();
    rst = 0;
    mon_en = 1;
    step();
    for (int d = 0; d < 2; d++) chk($sformatf("%0d.reset_state", d), rnd_state[d], '0);
    send(0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, PT);
    wait_out(0, 0);
    send(1, 128'h8ea2b7ca516745bfeafc49904b496089, PT);
    wait_out(1, 0);
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 6; i++) begin
        expand(d, {rand128(), rand128()});
        pt = rand128();
        send(d, encrypt(d, pt), pt);
        wait_out(d, i == 0 ? 5 : $urandom_range(0, 3));
        repeat ($urandom_range(0, 2)) step();
      end
    pt = rand128();
    send(0, encrypt(0, pt), pt);
    for (int i = 0; i < 20 && rk_idx[0] != 4'd4; i++) step();
    chk("0.reached_cnt4", 128'(rk_idx[0]), 128'(4));
    rst = 1;
    step();
    rst = 0;
    step();
    chk("0.reset_clears_state", rnd_state[0], '0);
    repeat (15) step();
    pt = rand128();
    send(0, encrypt(0, pt), pt);
    wait_out(0, 1);
    for (int i = 0; i < 3; i++) pts[i] = rand128();
    out_ready[0] = 1;
    in_valid[0] = 1;
    for (int i = 0; i < 3; i++) begin
      int n;
      n = acc_n[0];
      in_data[0] = encrypt(0, pts[i]);
      cur_pt[0] = pts[i];
      for (int k = 0; k < 40 && acc_n[0] == n; k++) step();
      chk("0.b2b_accept", 128'(acc_n[0] - n), 128'(1));
      acc[i] = acc_cyc[0];
    end
    in_valid[0] = 0;
    for (int k = 0; k < 40 && busy[0]; k++) step();
    chk("0.b2b_drain", 128'(busy[0]), 128'(0));
    out_ready[0] = 0;
    chk("0.b2b_spacing1", 128'(acc[1] - acc[0]), 128'(12));
    chk("0.b2b_spacing2", 128'(acc[2] - acc[1]), 128'(12));
`ifdef INV_CIPHER_ABORT_EN
    pt = rand128();
    send(0, encrypt(0, pt), pt);
    for (int i = 0; i < 20 && rk_idx[0] != 4'd7; i++) step();
    chk("0.reached_cnt7", 128'(rk_idx[0]), 128'(7));
    abort[0] = 1;
    step();
    abort[0] = 0;
    repeat (15) step();
    abort[0] = 1;
    pt = rand128();
    send(0, encrypt(0, pt), pt);
    abort[0] = 0;
    wait_out(0, 0);
`endif
    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
